// File: rtl/huf_pkg.sv
// Shared constants and FSM state type for the Huffman table controller.
package huf_pkg;
  localparam int NUM_SYM = 10;
  localparam int CNT_W   = 8;
  localparam int CODE_W  = 6;
  localparam int LEN_W   = 3;

  // Empty table entry: marker bit only, i.e. a zero-length code.
  localparam logic [CODE_W-1:0] CODE_RST = 6'b000001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    CLR   = 3'd2,
    BUILD = 3'd3,
    LATCH = 3'd4,
    READY = 3'd5
  } state_e;
endpackage

// File: rtl/huf_ctrl_if.sv
// Digit stream handshake. Sym_Valid/Sym_Data come from the master; a transfer
// happens on a rising clock edge where Sym_Valid and Sym_Ready are both 1.
interface huf_ctrl_if;
  logic       Sym_Valid;
  logic       Sym_Ready;
  logic [3:0] Sym_Data;

  modport master (output Sym_Valid, output Sym_Data, input Sym_Ready);
  modport slave  (input Sym_Valid, input Sym_Data, output Sym_Ready);
endinterface

// File: rtl/huf_code_len.sv
// Leading-one detector: code word with leading-1 marker -> code length.
module huf_code_len
  import huf_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [LEN_W-1:0]  len_o
);
  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    len_o = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (code_i[i]) len_o = LEN_W'(i);
    end
  end
endmodule

// File: rtl/huf_ctrl.sv
// Frame controller around an external Huffman encoder: counts digits, resets and
// runs the encoder, latches its code table. Optional build timeout: HUF_CTRL_TIMEOUT_EN.
module huf_ctrl
  import huf_pkg::*;
#(
  parameter logic [7:0] FRAME_LEN = 8'd100,
  parameter logic [7:0] TIMEOUT   = 8'd200
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  huf_ctrl_if.slave                 sym,
  output logic                      Huf_Rst_n,
  output logic                      Huf_En,
  output logic [NUM_SYM*CNT_W-1:0]  Huf_Count,
  input  logic [NUM_SYM*CODE_W-1:0] Huf_Code,
  input  logic                      Huf_Re,
  input  logic [3:0]                Lookup_Digit,
  output logic [CODE_W-1:0]         Lookup_Code,
  output logic [LEN_W-1:0]          Lookup_Len,
  output logic                      Done,
  output logic                      Err,
  output state_e                    Dbg_State
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NUM_SYM];
  logic [CNT_W-1:0]  cnt_d [NUM_SYM];
  logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [CODE_W-1:0] tbl_q [NUM_SYM];
  logic [CODE_W-1:0] tbl_d [NUM_SYM];
  logic              rst_n_q;
  logic              xfer;
  logic [CODE_W-1:0] code_sel;

`ifdef HUF_CTRL_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`else
  logic       unused_tmo;
  assign unused_tmo = ^TIMEOUT;
`endif

  assign xfer          = sym.Sym_Valid && (state_q == COUNT);
  assign sym.Sym_Ready = (state_q == COUNT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sym_cnt_d = sym_cnt_q;
    tbl_d     = tbl_q;
`ifdef HUF_CTRL_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE, READY: begin
        if (Start) begin
          state_d   = COUNT;
          cnt_d     = '{default: '0};
          sym_cnt_d = '0;
`ifdef HUF_CTRL_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      COUNT: begin
        // Digits 10..15 are consumed by the handshake but never counted.
        if (xfer && (sym.Sym_Data < 4'(NUM_SYM))) begin
          for (int i = 0; i < NUM_SYM; i++) begin
            if (sym.Sym_Data == 4'(i)) cnt_d[i] = cnt_q[i] + 8'd1;
          end
          sym_cnt_d = sym_cnt_q + 8'd1;
          if (sym_cnt_q + 8'd1 == FRAME_LEN) state_d = CLR;
        end
      end
      CLR: begin
        state_d = BUILD;
`ifdef HUF_CTRL_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      BUILD: begin
        if (Huf_Re) begin
          state_d = LATCH;
        end
`ifdef HUF_CTRL_TIMEOUT_EN
        else if (tmo_q == TIMEOUT - 8'd1) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      LATCH: begin
        for (int i = 0; i < NUM_SYM; i++) tbl_d[i] = Huf_Code[i*CODE_W +: CODE_W];
        state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '{default: '0};
      sym_cnt_q <= '0;
      tbl_q     <= '{default: CODE_RST};
      rst_n_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sym_cnt_q <= sym_cnt_d;
      tbl_q     <= tbl_d;
      // Registered from next state so the encoder reset is glitch-free and low exactly in CLR.
      rst_n_q   <= (state_d != CLR);
    end
  end

`ifdef HUF_CTRL_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  assign Huf_Rst_n = rst_n_q;
  assign Huf_En    = (state_q == BUILD);
  assign Done      = (state_q == READY);
  assign Dbg_State = state_q;

  always_comb begin
    Huf_Count = '0;
    for (int i = 0; i < NUM_SYM; i++) Huf_Count[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  always_comb begin
    code_sel = '0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if (Lookup_Digit == 4'(i)) code_sel = tbl_q[i];
    end
  end

  assign Lookup_Code = code_sel;

  huf_code_len u_code_len (
    .code_i (code_sel),
    .len_o  (Lookup_Len)
  );
endmodule

// File: tb/tb_huf_ctrl.sv
// Scoreboard bench for huf_ctrl: two instances (FRAME_LEN 10 / 100), encoder stubbed.
module tb_huf_ctrl;
  import huf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];
  int   model_a [NUM_SYM];

  logic        a_start, a_re, a_rst_o, a_en, a_done, a_err;
  logic [79:0] a_cnt;
  logic [59:0] a_code;
  logic [3:0]  a_dig;
  logic [5:0]  a_lcode;
  logic [2:0]  a_llen;
  state_e      a_state;
  huf_ctrl_if  a_sym ();

  logic        b_start, b_re, b_rst_o, b_en, b_done, b_err;
  logic [79:0] b_cnt;
  logic [59:0] b_code;
  logic [3:0]  b_dig;
  logic [5:0]  b_lcode;
  logic [2:0]  b_llen;
  state_e      b_state;
  huf_ctrl_if  b_sym ();

  huf_ctrl #(.FRAME_LEN(8'd10), .TIMEOUT(8'd20)) dut_a (
    .Clk(clk), .Reset(rst_n), .Start(a_start), .sym(a_sym), .Huf_Rst_n(a_rst_o),
    .Huf_En(a_en), .Huf_Count(a_cnt), .Huf_Code(a_code), .Huf_Re(a_re),
    .Lookup_Digit(a_dig), .Lookup_Code(a_lcode), .Lookup_Len(a_llen),
    .Done(a_done), .Err(a_err), .Dbg_State(a_state));

  huf_ctrl #(.FRAME_LEN(8'd100), .TIMEOUT(8'd20)) dut_b (
    .Clk(clk), .Reset(rst_n), .Start(b_start), .sym(b_sym), .Huf_Rst_n(b_rst_o),
    .Huf_En(b_en), .Huf_Count(b_cnt), .Huf_Code(b_code), .Huf_Re(b_re),
    .Lookup_Digit(b_dig), .Lookup_Code(b_lcode), .Lookup_Len(b_llen),
    .Done(b_done), .Err(b_err), .Dbg_State(b_state));

  // ---- driver tasks (no checking) ----
  task automatic a_start_frame();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < NUM_SYM; i++) model_a[i] = 0;
  endtask

  task automatic a_send(input logic [3:0] d);
    a_sym.Sym_Valid = 1'b1;
    a_sym.Sym_Data  = d;
    @(negedge clk);
    a_sym.Sym_Valid = 1'b0;
    if (d < 4'd10) model_a[d] = model_a[d] + 1;
  endtask

  task automatic a_build_to_ready(input logic [59:0] code);
    a_code = code;
    a_re   = 1'b1;
    @(negedge clk);
    a_re   = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_model_a();
    for (int i = 0; i < NUM_SYM; i++) exp_q.push_back(8'(model_a[i]));
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (a_state !== IDLE) begin n_err++; $display("FAIL rst_state got=%0d exp=%0d", a_state, IDLE); end
    n_vec++; if (a_rst_o !== 1'b0) begin n_err++; $display("FAIL rst_huf_rst_n got=%b exp=0", a_rst_o); end
    n_vec++; if ({a_en, a_done, a_err} !== 3'b000) begin n_err++; $display("FAIL rst_en_done_err got=%b exp=000", {a_en, a_done, a_err}); end
    n_vec++; if (a_cnt !== 80'd0) begin n_err++; $display("FAIL rst_count got=%h exp=0", a_cnt); end
    n_vec++; if ({a_lcode, a_llen} !== {6'b000001, 3'd0}) begin n_err++; $display("FAIL rst_lookup got=%b/%0d exp=000001/0", a_lcode, a_llen); end
    n_vec++; if (a_sym.Sym_Ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%b exp=0", a_sym.Sym_Ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if ({a_rst_o, b_rst_o} !== 2'b11) begin n_err++; $display("FAIL rst_release_huf_rst_n got=%b exp=11", {a_rst_o, b_rst_o}); end
  endtask

  task automatic test_idle_valid();
    a_sym.Sym_Valid = 1'b1;
    a_sym.Sym_Data  = 4'd3;
    repeat (4) begin
      @(negedge clk);
      n_vec++; if (a_sym.Sym_Ready !== 1'b0) begin n_err++; $display("FAIL idle_ready got=%b exp=0", a_sym.Sym_Ready); end
    end
    a_sym.Sym_Valid = 1'b0;
    n_vec++; if (a_cnt !== 80'd0 || a_state !== IDLE) begin n_err++; $display("FAIL idle_no_xfer got=%h/%0d exp=0/%0d", a_cnt, a_state, IDLE); end
  endtask

  task automatic test_uniform();
    logic [59:0] codes;
    logic [5:0]  e;
    int kraft;
    a_start_frame();
    n_vec++; if (a_state !== COUNT || a_sym.Sym_Ready !== 1'b1) begin n_err++; $display("FAIL uni_count got=%0d/%b exp=%0d/1", a_state, a_sym.Sym_Ready, COUNT); end
    for (int d = 0; d < 9; d++) a_send(4'(d));
    n_vec++; if (a_state !== COUNT) begin n_err++; $display("FAIL uni_early_close got=%0d exp=%0d", a_state, COUNT); end
    a_send(4'd9);
    n_vec++; if (a_state !== CLR || a_rst_o !== 1'b0 || a_sym.Sym_Ready !== 1'b0 || a_en !== 1'b0)
      begin n_err++; $display("FAIL uni_clr got=%0d rst_n=%b rdy=%b en=%b exp=%0d/0/0/0", a_state, a_rst_o, a_sym.Sym_Ready, a_en, CLR); end
    push_model_a();
    for (int i = 0; i < NUM_SYM; i++) begin
      e = 6'(exp_q.pop_front());
      n_vec++; if (a_cnt[i*8 +: 8] !== 8'(e)) begin n_err++; $display("FAIL uni_count%0d got=%0d exp=%0d", i, a_cnt[i*8 +: 8], e); end
    end
    @(negedge clk);
    n_vec++; if (a_state !== BUILD || a_rst_o !== 1'b1 || a_en !== 1'b1) begin n_err++; $display("FAIL uni_build got=%0d rst_n=%b en=%b exp=%0d/1/1", a_state, a_rst_o, a_en, BUILD); end
    repeat (2) @(negedge clk);
    n_vec++; if (a_state !== BUILD || a_done !== 1'b0) begin n_err++; $display("FAIL uni_build_hold got=%0d/%b exp=%0d/0", a_state, a_done, BUILD); end
    for (int i = 0; i < NUM_SYM; i++) codes[i*6 +: 6] = (i < 6) ? 6'(8 + i) : 6'(28 + i - 6);
    a_code = codes;
    a_re   = 1'b1;
    @(negedge clk);
    a_re   = 1'b0;
    n_vec++; if (a_state !== LATCH || a_en !== 1'b0) begin n_err++; $display("FAIL uni_latch got=%0d/%b exp=%0d/0", a_state, a_en, LATCH); end
    @(negedge clk);
    n_vec++; if (a_done !== 1'b1 || a_state !== READY) begin n_err++; $display("FAIL uni_done got=%b/%0d exp=1/%0d", a_done, a_state, READY); end
    kraft = 0;
    for (int d = 0; d < NUM_SYM; d++) exp_q.push_back({2'b00, codes[d*6 +: 6]});
    for (int d = 0; d < NUM_SYM; d++) begin
      a_dig = 4'(d);
      #1;
      e = 6'(exp_q.pop_front());
      n_vec++; if (a_lcode !== e) begin n_err++; $display("FAIL uni_code%0d got=%b exp=%b", d, a_lcode, e); end
      n_vec++; if (a_llen !== 3'd3 && a_llen !== 3'd4) begin n_err++; $display("FAIL uni_len%0d got=%0d exp=3or4", d, a_llen); end
      kraft += 64 >> a_llen;
    end
    n_vec++; if (kraft !== 64) begin n_err++; $display("FAIL uni_kraft got=%0d/64 exp=64/64", kraft); end
    a_dig = 4'd12;
    #1;
    n_vec++; if ({a_lcode, a_llen} !== 9'd0) begin n_err++; $display("FAIL uni_bad_digit got=%b/%0d exp=0/0", a_lcode, a_llen); end
    a_dig = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_discard();
    logic [7:0] e;
    a_start_frame();
    a_send(4'd12);
    n_vec++; if (a_cnt !== 80'd0 || a_state !== COUNT) begin n_err++; $display("FAIL disc_12 got=%h/%0d exp=0/%0d", a_cnt, a_state, COUNT); end
    for (int k = 0; k < 10; k++) begin
      a_send(4'($urandom_range(0, 9)));
      if (k < 9) begin
        n_vec++; if (a_state !== COUNT) begin n_err++; $display("FAIL disc_early k=%0d got=%0d exp=%0d", k, a_state, COUNT); end
      end
    end
    n_vec++; if (a_state !== CLR || a_sym.Sym_Ready !== 1'b0) begin n_err++; $display("FAIL disc_clr got=%0d/%b exp=%0d/0", a_state, a_sym.Sym_Ready, CLR); end
    push_model_a();
    for (int i = 0; i < NUM_SYM; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (a_cnt[i*8 +: 8] !== e) begin n_err++; $display("FAIL disc_count%0d got=%0d exp=%0d", i, a_cnt[i*8 +: 8], e); end
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    logic [79:0] snap;
    snap = a_cnt;
    a_sym.Sym_Valid = 1'b1;
    a_sym.Sym_Data  = 4'd5;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    n_vec++; if (a_state !== BUILD || a_cnt !== snap) begin n_err++; $display("FAIL busy_start got=%0d/%h exp=%0d/%h", a_state, a_cnt, BUILD, snap); end
    a_build_to_ready(60'h0123456789abcde);
    repeat (3) @(negedge clk);
    n_vec++; if (a_done !== 1'b1 || a_cnt !== snap || a_sym.Sym_Ready !== 1'b0)
      begin n_err++; $display("FAIL busy_ready got=%b/%h/%b exp=1/%h/0", a_done, a_cnt, a_sym.Sym_Ready, snap); end
    a_sym.Sym_Valid = 1'b0;
  endtask

  task automatic test_long_frame();
    logic [59:0] codes;
    logic [7:0]  e;
    int L;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_sym.Sym_Valid = 1'b1;
    b_sym.Sym_Data  = 4'd7;
    repeat (99) @(negedge clk);
    n_vec++; if (b_state !== COUNT) begin n_err++; $display("FAIL long_early got=%0d exp=%0d", b_state, COUNT); end
    @(negedge clk);
    b_sym.Sym_Valid = 1'b0;
    n_vec++; if (b_state !== CLR) begin n_err++; $display("FAIL long_clr got=%0d exp=%0d", b_state, CLR); end
    for (int i = 0; i < NUM_SYM; i++) exp_q.push_back((i == 7) ? 8'd100 : 8'd0);
    for (int i = 0; i < NUM_SYM; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (b_cnt[i*8 +: 8] !== e) begin n_err++; $display("FAIL long_count%0d got=%0d exp=%0d", i, b_cnt[i*8 +: 8], e); end
    end
    @(negedge clk);
    for (int i = 0; i < NUM_SYM; i++) begin
      L = $urandom_range(0, 5);
      codes[i*6 +: 6] = 6'((1 << L) | ($urandom & ((1 << L) - 1)));
      exp_q.push_back({2'b00, codes[i*6 +: 6]});
      exp_q.push_back(8'(L));
    end
    b_code = codes;
    b_re   = 1'b1;
    @(negedge clk);
    b_re   = 1'b0;
    @(negedge clk);
    b_code = ~codes;
    n_vec++; if (b_done !== 1'b1) begin n_err++; $display("FAIL long_done got=%b exp=1", b_done); end
    for (int d = 0; d < NUM_SYM; d++) begin
      b_dig = 4'(d);
      #1;
      e = exp_q.pop_front();
      n_vec++; if (b_lcode !== 6'(e)) begin n_err++; $display("FAIL long_code%0d got=%b exp=%b", d, b_lcode, 6'(e)); end
      e = exp_q.pop_front();
      n_vec++; if (b_llen !== 3'(e)) begin n_err++; $display("FAIL long_len%0d got=%0d exp=%0d", d, b_llen, e); end
    end
    @(negedge clk);
  endtask

  task automatic a_frame_to_build();
    a_start_frame();
    for (int k = 0; k < 10; k++) a_send(4'($urandom_range(0, 9)));
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    a_frame_to_build();
    cyc = 0;
    for (int t = 0; t < 60 && a_state == BUILD; t++) begin
      cyc++;
      @(negedge clk);
    end
`ifdef HUF_CTRL_TIMEOUT_EN
    n_vec++; if (cyc !== 20) begin n_err++; $display("FAIL tmo_cycles got=%0d exp=20", cyc); end
    n_vec++; if (a_err !== 1'b1 || a_en !== 1'b0 || a_state !== IDLE || a_done !== 1'b0)
      begin n_err++; $display("FAIL tmo_state got err=%b en=%b st=%0d done=%b exp=1/0/%0d/0", a_err, a_en, a_state, a_done, IDLE); end
    a_start_frame();
    n_vec++; if (a_err !== 1'b0 || a_state !== COUNT) begin n_err++; $display("FAIL tmo_clear got=%b/%0d exp=0/%0d", a_err, a_state, COUNT); end
    for (int k = 0; k < 10; k++) a_send(4'd1);
    @(negedge clk);
`else
    n_vec++; if (cyc !== 60 || a_state !== BUILD || a_err !== 1'b0 || a_en !== 1'b1)
      begin n_err++; $display("FAIL notmo_wait got cyc=%0d st=%0d err=%b en=%b exp=60/%0d/0/1", cyc, a_state, a_err, a_en, BUILD); end
`endif
    a_build_to_ready(60'h0);
  endtask

  task automatic test_reset_mid_build();
    logic [7:0] e;
    a_frame_to_build();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (a_state !== IDLE || a_en !== 1'b0 || a_rst_o !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0)
      begin n_err++; $display("FAIL mid_rst_ctl got st=%0d en=%b rst_n=%b done=%b err=%b exp=%0d/0/0/0/0", a_state, a_en, a_rst_o, a_done, a_err, IDLE); end
    n_vec++; if (a_cnt !== 80'd0 || a_lcode !== 6'b000001) begin n_err++; $display("FAIL mid_rst_data got=%h/%b exp=0/000001", a_cnt, a_lcode); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_start_frame();
    for (int k = 0; k < 10; k++) a_send(4'($urandom_range(0, 9)));
    n_vec++; if (a_state !== CLR) begin n_err++; $display("FAIL clean_clr got=%0d exp=%0d", a_state, CLR); end
    push_model_a();
    for (int i = 0; i < NUM_SYM; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (a_cnt[i*8 +: 8] !== e) begin n_err++; $display("FAIL clean_count%0d got=%0d exp=%0d", i, a_cnt[i*8 +: 8], e); end
    end
    @(negedge clk);
    a_build_to_ready({10{6'b000110}});
    a_dig = 4'd3;
    #1;
    n_vec++; if (a_done !== 1'b1 || a_lcode !== 6'b000110 || a_llen !== 3'd2)
      begin n_err++; $display("FAIL clean_done got=%b/%b/%0d exp=1/000110/2", a_done, a_lcode, a_llen); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_re = 1'b0; a_code = '0; a_dig = 4'd0;
    b_start = 1'b0; b_re = 1'b0; b_code = '0; b_dig = 4'd0;
    a_sym.Sym_Valid = 1'b0; a_sym.Sym_Data = 4'd0;
    b_sym.Sym_Valid = 1'b0; b_sym.Sym_Data = 4'd0;
    test_reset();
    test_idle_valid();
    test_uniform();
    test_discard();
    test_busy_ignore();
    test_long_frame();
    test_timeout();
    test_reset_mid_build();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
